matrix_loader: RTL and testbench
================================

# matrix_loader

Upstream feeder for the 10x10 8-bit matrix multiplier. Accepts a valid/ready byte stream holding matrix A then matrix B, both row-major. Writes each element into the A and B matrix memories with generated row/column addresses. Pulses `load_done` after the last B element is written, which is the start condition for the multiply control path.

## Interface
- `N`, 10, matrix dimension (rows = cols)
- `DATA_W`, 8, element width
- `ADDR_W`, 4, row/column address width; must satisfy 2^ADDR_W >= N

- `clk`  in  1  single clock; all state updates on rising edge
- `reset_n`  in  1  asynchronous, active-low reset
- `start`  in  1  begin a load; sampled only in IDLE
- `in_valid`  in  1  stream byte present
- `in_data`  in  DATA_W  stream byte
- `in_ready`  out  1  loader accepts a byte this cycle
- `en_WriteMat_A`  out  1  write strobe, matrix A memory
- `rowAddr_A`, `colAddr_A`  out  ADDR_W each  A write address
- `dataMat_A`  out  DATA_W  A write data
- `en_WriteMat_B`  out  1  write strobe, matrix B memory
- `rowAddr_B`, `colAddr_B`  out  ADDR_W each  B write address
- `dataMat_B`  out  DATA_W  B write data
- `busy`  out  1  high from acceptance of `start` until `load_done`
- `load_done`  out  1  one-cycle pulse; A and B fully written

## Operation
- States: IDLE, LOAD_A, LOAD_B, DONE.
- A beat is accepted when `in_valid && in_ready`.
- Counters: `row` and `col`, each ADDR_W bits.

**IDLE**
- `in_ready` = 0.
- `start` = 1 → LOAD_A. `row`/`col` cleared to 0; `busy` set.

**LOAD_A**
- `in_ready` = 1.
- Each accepted beat: registers row, col and `in_data` into the A write port. `en_WriteMat_A` is high in the next cycle.
- `col` increments. At `col == N-1`, `col` wraps to 0 and `row` increments.
- Accepting (N-1, N-1): clears `row`/`col` and moves to LOAD_B. There is no bubble; `in_ready` stays 1.

**LOAD_B**
- Same behaviour as LOAD_A, targeting the B port.
- Accepting (N-1, N-1) → DONE.

**DONE**
- `in_ready` = 0.
- Lasts exactly one cycle; next state is IDLE.

**General rules**
- `start` outside IDLE is ignored.
- `in_valid` low stalls the load with no state change and no write strobe.
- Bytes offered while `in_ready` = 0 are not consumed.
- At most one of `en_WriteMat_A` / `en_WriteMat_B` is high per cycle.
- Address and data ports hold their last value when the strobe is low.
- Exactly N*N A writes and N*N B writes per load, in row-major order.
- `row` and `col` never exceed N-1.

## Timing
- Reset (async assert, sync release), all outputs 0: `in_ready`, both write strobes, all addresses, both data ports, `busy`, `load_done`.
- Reset puts the state in IDLE and clears the counters.
- Reset mid-load aborts the load:
  - no further writes and no `load_done`;
  - memory contents already written are left as is;
  - a fresh `start` restarts the load at (0,0) of A.
- `start` seen high in IDLE at edge t: `in_ready` is high from cycle t+1.
- Write latency: a beat accepted at edge t produces its strobe, address and data during cycle t+1 (one registered stage).
- A/B boundary: the last A beat is accepted at edge t, and the first B beat may be accepted at edge t+1. `en_WriteMat_A` (9,9) is high in the same cycle that LOAD_B first accepts.
- End of load: the last B beat is accepted at edge t.
  - Cycle t+1: state DONE; `en_WriteMat_B` for (N-1, N-1) high.
  - Cycle t+2: `load_done` = 1 for one cycle; `busy` = 0; state IDLE.
- Minimum load time, no stalls: 2*N*N + 2 cycles from `start` to `load_done` (202 for N = 10).
- `start` held high through DONE launches a new load only from the IDLE cycle where `load_done` is high.

## Test plan
- **Reset values.** Assert `reset_n` = 0 mid-cycle → all outputs 0 immediately. Release, then hold `start` = 0 for 20 cycles → `in_ready` stays 0 and no strobes occur.
- **Full back-to-back load.** `start`, then 200 bytes with value (index mod 256) and `in_valid` held high.
  - A(r,c) is written with 10r+c; B(r,c) with 100+10r+c.
  - The A-to-B switch has no gap.
  - `load_done` fires exactly once, 202 cycles after `start`.
- **Random stalls.** Drop `in_valid` for random gaps of 0-5 cycles → same memory contents as the back-to-back load, each write one cycle after its accept, no duplicate or missing addresses.
- **Stray start.** Pulse `start` during LOAD_A at element (3,7) and again during LOAD_B → counters unaffected, only one `load_done`.
- **Reset mid-load.** Assert reset during LOAD_B at (5,2), then `start` plus 200 new bytes → writes restart at A(0,0), no `load_done` from the aborted load, final memories hold the new data.
- **Idle stream.** Hold `in_valid` = 1 while IDLE and during DONE → no bytes accepted (`in_ready` = 0) and no write strobes.

Source files
------------

// File: rtl/matrix_loader.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : matrix_loader
// Description : Upstream feeder for the NxN matrix multiplier. Consumes a
//               valid/ready byte stream carrying matrix A then matrix B, both
//               row-major. Each element is written into the A or B matrix
//               memory with generated row/column addresses. A one-cycle
//               load_done pulse marks the moment both memories are complete.
// Revision    : 1.0 - initial release
// ============================================================================
module matrix_loader #(
  parameter int N      = 10,
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4    // must satisfy 2**ADDR_W >= N
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              en_WriteMat_A,
  output logic [ADDR_W-1:0] rowAddr_A,
  output logic [ADDR_W-1:0] colAddr_A,
  output logic [DATA_W-1:0] dataMat_A,
  output logic              en_WriteMat_B,
  output logic [ADDR_W-1:0] rowAddr_B,
  output logic [ADDR_W-1:0] colAddr_B,
  output logic [DATA_W-1:0] dataMat_B,
  output logic              busy,
  output logic              load_done
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_LOAD_A = 2'd1;
  localparam logic [1:0] S_LOAD_B = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  localparam logic [ADDR_W-1:0] C_LAST = ADDR_W'(N - 1);
  localparam logic [ADDR_W-1:0] C_ONE  = ADDR_W'(1);

  logic [1:0]        r_state;
  logic [ADDR_W-1:0] r_row;
  logic [ADDR_W-1:0] r_col;

  logic              r_en_a;
  logic [ADDR_W-1:0] r_row_a;
  logic [ADDR_W-1:0] r_col_a;
  logic [DATA_W-1:0] r_data_a;
  logic              r_en_b;
  logic [ADDR_W-1:0] r_row_b;
  logic [ADDR_W-1:0] r_col_b;
  logic [DATA_W-1:0] r_data_b;
  logic              r_busy;
  logic              r_load_done;

  logic w_loading;
  logic w_accept;
  logic w_accept_a;
  logic w_accept_b;
  logic w_last_col;
  logic w_last_elem;

  // Ready is a pure decode of the state so it drops to 0 the instant reset asserts
  assign w_loading   = (r_state == S_LOAD_A) || (r_state == S_LOAD_B);
  assign w_accept    = in_valid && w_loading;
  assign w_accept_a  = w_accept && (r_state == S_LOAD_A);
  assign w_accept_b  = w_accept && (r_state == S_LOAD_B);
  assign w_last_col  = (r_col == C_LAST);
  assign w_last_elem = w_last_col && (r_row == C_LAST);

  // Sequencer: state and the row-major element counters
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_row   <= '0;
      r_col   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state <= S_LOAD_A;
            r_row   <= '0;
            r_col   <= '0;
          end
        end
        S_LOAD_A, S_LOAD_B: begin
          if (w_accept) begin
            if (w_last_elem) begin
              // Counters restart immediately so the first B beat can follow
              // the last A beat without a bubble.
              r_row   <= '0;
              r_col   <= '0;
              r_state <= (r_state == S_LOAD_A) ? S_LOAD_B : S_DONE;
            end else if (w_last_col) begin
              r_col <= '0;
              r_row <= r_row + C_ONE;
            end else begin
              r_col <= r_col + C_ONE;
            end
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // A write port: one registered stage after the accepted beat; address/data hold otherwise
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_en_a   <= 1'b0;
      r_row_a  <= '0;
      r_col_a  <= '0;
      r_data_a <= '0;
    end else begin
      r_en_a <= w_accept_a;
      if (w_accept_a) begin
        r_row_a  <= r_row;
        r_col_a  <= r_col;
        r_data_a <= in_data;
      end
    end
  end

  // B write port: same pipeline as the A port
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_en_b   <= 1'b0;
      r_row_b  <= '0;
      r_col_b  <= '0;
      r_data_b <= '0;
    end else begin
      r_en_b <= w_accept_b;
      if (w_accept_b) begin
        r_row_b  <= r_row;
        r_col_b  <= r_col;
        r_data_b <= in_data;
      end
    end
  end

  // Status: busy spans start acceptance through DONE; load_done pulses in the following IDLE cycle
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_busy      <= 1'b0;
      r_load_done <= 1'b0;
    end else begin
      r_load_done <= (r_state == S_DONE);
      if (r_state == S_IDLE && start) begin
        r_busy <= 1'b1;
      end else if (r_state == S_DONE) begin
        r_busy <= 1'b0;
      end
    end
  end

  assign in_ready      = w_loading;
  assign en_WriteMat_A = r_en_a;
  assign rowAddr_A     = r_row_a;
  assign colAddr_A     = r_col_a;
  assign dataMat_A     = r_data_a;
  assign en_WriteMat_B = r_en_b;
  assign rowAddr_B     = r_row_b;
  assign colAddr_B     = r_col_b;
  assign dataMat_B     = r_data_b;
  assign busy          = r_busy;
  assign load_done     = r_load_done;

endmodule
`default_nettype wire

// File: tb/tb_matrix_loader.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_matrix_loader
// Description : Scoreboard bench for matrix_loader. Every accepted beat pushes
//               its expected write (matrix, row, col, data); every write strobe
//               pops and compares. Shadow memories collect the written data.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_matrix_loader;

  localparam int N  = 10;
  localparam int DW = 8;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          start;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_ready;
  logic          en_WriteMat_A;
  logic [AW-1:0] rowAddr_A;
  logic [AW-1:0] colAddr_A;
  logic [DW-1:0] dataMat_A;
  logic          en_WriteMat_B;
  logic [AW-1:0] rowAddr_B;
  logic [AW-1:0] colAddr_B;
  logic [DW-1:0] dataMat_B;
  logic          busy;
  logic          load_done;

  matrix_loader #(.N(N), .DATA_W(DW), .ADDR_W(AW)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .start         (start),
    .in_valid      (in_valid),
    .in_data       (in_data),
    .in_ready      (in_ready),
    .en_WriteMat_A (en_WriteMat_A),
    .rowAddr_A     (rowAddr_A),
    .colAddr_A     (colAddr_A),
    .dataMat_A     (dataMat_A),
    .en_WriteMat_B (en_WriteMat_B),
    .rowAddr_B     (rowAddr_B),
    .colAddr_B     (colAddr_B),
    .dataMat_B     (dataMat_B),
    .busy          (busy),
    .load_done     (load_done)
  );

  always #5 clk = ~clk;

  int n_cmp     = 0;
  int n_err     = 0;
  int n_done    = 0;
  int edge_cnt  = 0;
  int done_edge = 0;

  logic [16:0] exp_q[$];          // {is_b, row, col, data}
  logic [DW-1:0] shadow [0:2*N*N-1];
  int            wr_cnt [0:2*N*N-1];
  logic [15:0]   last_a;
  logic [15:0]   last_b;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [36:0] all_outputs();
    return {in_ready, en_WriteMat_A, en_WriteMat_B, rowAddr_A, colAddr_A, dataMat_A,
            rowAddr_B, colAddr_B, dataMat_B, busy, load_done};
  endfunction

  // Expected write for stream beat k: first N*N beats go to A, rest to B, row-major
  function automatic logic [16:0] beat_ent(input int k, input logic [7:0] xr);
    int m;
    m = k % (N*N);
    return {(k >= N*N), 4'(m / N), 4'(m % N), 8'(k) ^ xr};
  endfunction

  // Called at each negedge while out of reset: scoreboard pop, hold checks, done tracking
  task automatic monitor();
    logic [16:0] got;
    logic [16:0] e;
    int idx;
    if (en_WriteMat_A && en_WriteMat_B)
      check_eq("wr_exclusive", en_WriteMat_B, 0);
    if (en_WriteMat_A || en_WriteMat_B) begin
      got = en_WriteMat_B ? {1'b1, rowAddr_B, colAddr_B, dataMat_B}
                          : {1'b0, rowAddr_A, colAddr_A, dataMat_A};
      check_eq("wr_q_depth", exp_q.size(), 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check_eq("wr_entry", got, e);
      end
      if (got[15:12] < N && got[11:8] < N) begin
        idx = (got[16] ? N*N : 0) + int'(got[15:12]) * N + int'(got[11:8]);
        shadow[idx] = got[7:0];
        wr_cnt[idx]++;
      end
    end else if (exp_q.size() != 0) begin
      check_eq("wr_latency", exp_q.size(), 0);
      exp_q.delete();
    end
    if (!en_WriteMat_A) check_eq("hold_A", {rowAddr_A, colAddr_A, dataMat_A}, last_a);
    else                last_a = {rowAddr_A, colAddr_A, dataMat_A};
    if (!en_WriteMat_B) check_eq("hold_B", {rowAddr_B, colAddr_B, dataMat_B}, last_b);
    else                last_b = {rowAddr_B, colAddr_B, dataMat_B};
    if (load_done) begin
      n_done++;
      done_edge = edge_cnt;
      check_eq("busy_at_done", busy, 0);
    end
  endtask

  // Drive one cycle of inputs; a beat counts as accepted if ready is high while driven
  task automatic tick(input logic s, input logic v, input logic [7:0] d,
                      input logic [16:0] ent, output bit acc);
    start    = s;
    in_valid = v;
    in_data  = d;
    acc      = v && (in_ready === 1'b1);
    if (acc) exp_q.push_back(ent);
    @(negedge clk);
    edge_cnt++;
    if (reset_n) monitor();
  endtask

  task automatic run_load(input int gap_max, input logic [7:0] xr, input bit stray,
                          input int abort_at, input bit chk_time);
    int  e0;
    int  n0;
    int  tries;
    int  gaps;
    bit  acc;
    n0 = n_done;
    e0 = edge_cnt;
    for (int i = 0; i < 2*N*N; i++) wr_cnt[i] = 0;
    tick(1'b1, 1'b0, 8'h00, 17'd0, acc);
    check_eq("busy_after_start", busy, 1);
    check_eq("ready_after_start", in_ready, 1);
    for (int k = 0; k < 2*N*N; k++) begin
      if (k == abort_at) return;
      gaps = (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0;
      for (int g = 0; g < gaps; g++) tick(1'b0, 1'b0, 8'($urandom), 17'd0, acc);
      tries = 0;
      acc   = 1'b0;
      while (!acc && tries < 20) begin
        tick(stray && (k == 37 || k == 137), 1'b1, 8'(k) ^ xr, beat_ent(k, xr), acc);
        tries++;
      end
      if (!acc) begin
        check_eq("accept_timeout", in_ready, 1);
        return;
      end
      if (k == N*N) check_eq("ab_no_gap", tries, 1);
    end
    // Keep offering bytes through DONE: none may be accepted
    tries = 0;
    while (n_done == n0 && tries < 10) begin
      tick(1'b0, 1'b1, 8'hEE, 17'd0, acc);
      check_eq("post_accept", acc, 0);
      tries++;
    end
    check_eq("load_done_seen", n_done - n0, 1);
    if (chk_time) check_eq("load_cycles", done_edge - e0, 2*N*N + 2);
    for (int i = 0; i < 3; i++) begin
      tick(1'b0, 1'b1, 8'hEE, 17'd0, acc);
      check_eq("idle_accept", acc, 0);
    end
    check_eq("load_done_once", n_done - n0, 1);
  endtask

  task automatic check_mem(input logic [7:0] xr);
    int bad_cnt;
    bad_cnt = 0;
    for (int k = 0; k < 2*N*N; k++)
      check_eq($sformatf("mem[%0d]", k), shadow[k], 8'(k) ^ xr);
    for (int k = 0; k < 2*N*N; k++)
      if (wr_cnt[k] != 1) bad_cnt++;
    check_eq("addr_write_once", bad_cnt, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc;
    int n0;
    reset_n  = 1'b1;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    for (int i = 0; i < 2*N*N; i++) begin
      shadow[i] = '0;
      wr_cnt[i] = 0;
    end

    // Reset asserted mid-cycle: outputs clear without waiting for a clock
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1 check_eq("reset_outputs", all_outputs(), 0);
    last_a = '0;
    last_b = '0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;

    // Idle with the stream valid: nothing accepted, nothing written
    for (int i = 0; i < 20; i++) begin
      tick(1'b0, 1'b1, 8'($urandom), 17'd0, acc);
      check_eq("idle_ready", in_ready, 0);
    end

    // Back-to-back load
    run_load(0, 8'h00, 1'b0, -1, 1'b1);
    check_mem(8'h00);

    // Random stalls with a different data pattern
    run_load(5, 8'h5C, 1'b0, -1, 1'b0);
    check_mem(8'h5C);

    // Stray start pulses during A and during B
    run_load(0, 8'h00, 1'b1, -1, 1'b1);
    check_mem(8'h00);

    // Abort during B just before element (5,2), then reload from scratch
    run_load(0, 8'h33, 1'b0, N*N + 5*N + 2, 1'b0);
    reset_n = 1'b0;
    #1 check_eq("abort_outputs", all_outputs(), 0);
    check_eq("abort_queue", exp_q.size(), 0);
    last_a = '0;
    last_b = '0;
    n0 = n_done;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 5; i++) tick(1'b0, 1'b0, 8'h00, 17'd0, acc);
    check_eq("abort_no_done", n_done, n0);
    run_load(2, 8'hA5, 1'b0, -1, 1'b0);
    check_mem(8'hA5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
